// File: rtl/sys_bus_arbiter_if.sv
// Native memory-port bundle: valid/ready handshake, 32-bit address and data, 4-bit write strobe.
// The master side issues requests and the slave side answers them with ready/rdata.
interface sys_bus_arbiter_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/sys_bus_arbiter.sv
// Two-master round-robin arbiter sharing one native memory port; each grant covers one transfer.
// Define BUS_TIMEOUT_EN to build the watchdog that ends transfers the slave never acknowledges.
module sys_bus_arbiter #(
  parameter int unsigned TIMEOUT  = 256,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst,
  sys_bus_arbiter_if.slave  m0,
  sys_bus_arbiter_if.slave  m1,
  sys_bus_arbiter_if.master mem,
  output logic [1:0]        grant,
  output logic              bus_err,
  output logic [31:0]       err_addr,
  input  logic              err_clr
);
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_e;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 32'd1);

  state_e      state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic        sel_valid_s;
  logic        timeout_s;
  logic        done_s;
  logic [31:0] addr_s;
  logic [31:0] rdata_s;

  // Owner's request, selected by the grant register.
  always_comb begin
    sel_valid_s = 1'b0;
    case (grant_q)
      2'b01:   sel_valid_s = m0.valid;
      2'b10:   sel_valid_s = m1.valid;
      default: sel_valid_s = 1'b0;
    endcase
  end

  assign addr_s    = grant_q[1] ? m1.addr : m0.addr;
  assign mem.addr  = addr_s;
  assign mem.wdata = grant_q[1] ? m1.wdata : m0.wdata;
  assign mem.wstrb = grant_q[1] ? m1.wstrb : m0.wstrb;
  assign mem.valid = sel_valid_s & ~timeout_s;
  assign done_s    = sel_valid_s & (mem.ready | timeout_s);
  assign rdata_s   = timeout_s ? ERR_DATA : mem.rdata;
  assign m0.ready  = done_s & grant_q[0];
  assign m1.ready  = done_s & grant_q[1];
  assign m0.rdata  = rdata_s;
  assign m1.rdata  = rdata_s;
  assign grant     = grant_q;

  // Arbitrate in IDLE; completion, timeout or a withdrawn request frees the bus.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (m0.valid && m1.valid) begin
          state_d      = ST_BUSY;
          grant_d      = last_grant_q ? 2'b01 : 2'b10;
          last_grant_d = ~last_grant_q;
        end else if (m0.valid) begin
          state_d      = ST_BUSY;
          grant_d      = 2'b01;
          last_grant_d = 1'b0;
        end else if (m1.valid) begin
          state_d      = ST_BUSY;
          grant_d      = 2'b10;
          last_grant_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (!sel_valid_s || mem.ready || timeout_s) begin
          state_d = ST_IDLE;
          grant_d = 2'b00;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // State, owner and round-robin pointer; master 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= 2'b00;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef BUS_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        bus_err_q, bus_err_d;
  logic [31:0] err_addr_q, err_addr_d;

  // A same-cycle mem_ready takes precedence over the timeout.
  assign timeout_s = (state_q == ST_BUSY) && sel_valid_s && !mem.ready && (cnt_q == TO_LAST);

  // Wait counter and sticky first-error capture; clearing beats a new error.
  always_comb begin
    cnt_d      = cnt_q;
    bus_err_d  = bus_err_q;
    err_addr_d = err_addr_q;
    if (state_q == ST_BUSY) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = 16'd0;
    end
    if (err_clr) begin
      bus_err_d  = 1'b0;
      err_addr_d = 32'h0000_0000;
    end else if (timeout_s && !bus_err_q) begin
      bus_err_d  = 1'b1;
      err_addr_d = addr_s;
    end else begin
      bus_err_d  = bus_err_q;
    end
  end

  // Watchdog registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= 16'd0;
      bus_err_q  <= 1'b0;
      err_addr_q <= 32'h0000_0000;
    end else begin
      cnt_q      <= cnt_d;
      bus_err_q  <= bus_err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign bus_err  = bus_err_q;
  assign err_addr = err_addr_q;
`else
  logic unused_cfg_s;

  assign timeout_s    = 1'b0;
  assign bus_err      = 1'b0;
  assign err_addr     = 32'h0000_0000;
  assign unused_cfg_s = ^{err_clr, TO_LAST};
`endif
endmodule

// File: tb/tb_sys_bus_arbiter.sv
// Self-checking bench for sys_bus_arbiter: vector table, directed corner sequences, and a
// randomized run against a transfer-level reference model (timeout cases need BUS_TIMEOUT_EN).
module tb_sys_bus_arbiter;
  localparam int unsigned TB_TO = 8;
  localparam logic [31:0] ERR_D = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        err_clr;
  logic [1:0]  grant;
  logic        bus_err;
  logic [31:0] err_addr;

  sys_bus_arbiter_if m0_if();
  sys_bus_arbiter_if m1_if();
  sys_bus_arbiter_if mem_if();

  sys_bus_arbiter #(.TIMEOUT(TB_TO), .ERR_DATA(ERR_D)) dut (
    .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if), .mem(mem_if),
    .grant(grant), .bus_err(bus_err), .err_addr(err_addr), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [2:0] in;   // m0_valid, m1_valid, mem_ready
    logic [1:0] g;    // expected grant
    logic [2:0] out;  // expected mem_valid, m0_ready, m1_ready
  } vec_t;
  vec_t vt [17];

  // reference model state for the random run
  int          owner;
  int          last;
  int          bcnt;
  logic        err_m;
  logic [31:0] erra_m;
  logic [1:0]  pend;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_if.valid = 1'b0; m0_if.addr = 32'h0; m0_if.wdata = 32'h0; m0_if.wstrb = 4'h0;
    m1_if.valid = 1'b0; m1_if.addr = 32'h0; m1_if.wdata = 32'h0; m1_if.wstrb = 4'h0;
    mem_if.ready = 1'b0; mem_if.rdata = 32'h0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One transfer by master m; slave answers in busy cycle 'lat' (never if lat < 0).
  task automatic xfer(input int m, input logic [31:0] a, input int lat, input logic [31:0] rd_in,
                      output int bcyc, output logic [31:0] rd_out, output logic mv_done);
    logic [1:0] oh;
    logic       done;
    oh = (m == 1) ? 2'b10 : 2'b01;
    bcyc = 0; rd_out = 32'h0; mv_done = 1'b0; done = 1'b0;
    if (m == 1) begin m1_if.valid = 1'b1; m1_if.addr = a; m1_if.wstrb = 4'h0; end
    else        begin m0_if.valid = 1'b1; m0_if.addr = a; m0_if.wstrb = 4'h0; end
    mem_if.rdata = rd_in;
    for (int c = 0; c < 40 && !done; c++) begin
      mem_if.ready = (lat >= 0) && (bcyc == lat);
      @(negedge clk);
      if (grant == oh) begin
        bcyc++;
        chkb("xfer_other_ready", (m == 1) ? m0_if.ready : m1_if.ready, 1'b0);
        if (mem_if.valid) chk("xfer_addr", mem_if.addr, a);
        if ((m == 1) ? m1_if.ready : m0_if.ready) begin
          done    = 1'b1;
          rd_out  = (m == 1) ? m1_if.rdata : m0_if.rdata;
          mv_done = mem_if.valid;
        end
      end
      @(posedge clk); #1;
    end
    chkb("xfer_completed", done, 1'b1);
    m0_if.valid = 1'b0; m1_if.valid = 1'b0; mem_if.ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got expired expected finish");
    $fatal(1);
  end

  initial begin
    int          bc;
    logic [31:0] rd;
    logic        mvd;
    int          c0done, c1done, m0cyc;
    logic [31:0] exp_a;

    // ---------------- reset state ----------------
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chkb("rst_mem_valid", mem_if.valid, 1'b0);
    chkb("rst_m0_ready", m0_if.ready, 1'b0);
    chkb("rst_m1_ready", m1_if.ready, 1'b0);
    chkb("rst_bus_err", bus_err, 1'b0);
    chk("rst_err_addr", err_addr, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // ---------------- vector table: tie fairness, turnaround, withdrawn request ----------------
    vt[0]  = {3'b000, 2'b00, 3'b000};
    vt[1]  = {3'b110, 2'b00, 3'b000};
    vt[2]  = {3'b111, 2'b01, 3'b110};
    vt[3]  = {3'b110, 2'b00, 3'b000};
    vt[4]  = {3'b111, 2'b10, 3'b101};
    vt[5]  = {3'b110, 2'b00, 3'b000};
    vt[6]  = {3'b111, 2'b01, 3'b110};
    vt[7]  = {3'b110, 2'b00, 3'b000};
    vt[8]  = {3'b110, 2'b10, 3'b100};
    vt[9]  = {3'b111, 2'b10, 3'b101};
    vt[10] = {3'b010, 2'b00, 3'b000};
    vt[11] = {3'b011, 2'b10, 3'b101};
    vt[12] = {3'b000, 2'b00, 3'b000};
    vt[13] = {3'b000, 2'b00, 3'b000};
    vt[14] = {3'b100, 2'b00, 3'b000};
    vt[15] = {3'b000, 2'b01, 3'b000};
    vt[16] = {3'b001, 2'b00, 3'b000};
    m0_if.addr = 32'h0000_0100; m0_if.wdata = 32'h1111_1111; m0_if.wstrb = 4'h0;
    m1_if.addr = 32'h0000_0200; m1_if.wdata = 32'hAABB_CCDD; m1_if.wstrb = 4'b0011;
    mem_if.rdata = 32'h0BAD_F00D;
    for (int i = 0; i < 17; i++) begin
      m0_if.valid  = vt[i].in[2];
      m1_if.valid  = vt[i].in[1];
      mem_if.ready = vt[i].in[0];
      @(negedge clk);
      chk("tbl_grant", 32'(grant), 32'(vt[i].g));
      chkb("tbl_mem_valid", mem_if.valid, vt[i].out[2]);
      chkb("tbl_m0_ready", m0_if.ready, vt[i].out[1]);
      chkb("tbl_m1_ready", m1_if.ready, vt[i].out[0]);
      chkb("tbl_bus_err", bus_err, 1'b0);
      if (vt[i].out[2]) begin
        chk("tbl_mem_addr", mem_if.addr, (vt[i].g == 2'b10) ? 32'h0000_0200 : 32'h0000_0100);
        chk("tbl_mem_wstrb", 32'(mem_if.wstrb), (vt[i].g == 2'b10) ? 32'd3 : 32'd0);
      end
      if (vt[i].out[1] || vt[i].out[0]) chk("tbl_rdata", m0_if.rdata, 32'h0BAD_F00D);
      @(posedge clk); #1;
    end
    idle_inputs();
    @(posedge clk); #1;

    // ---------------- single read, ready 3 cycles after mem_valid ----------------
    xfer(0, 32'h0000_0100, 3, 32'h1234_5678, bc, rd, mvd);
    chk("single_busy_cycles", 32'(bc), 32'd4);
    chk("single_rdata", rd, 32'h1234_5678);
    chkb("single_mem_valid_at_ready", mvd, 1'b1);
    @(negedge clk);
    chkb("single_no_second_ready", m0_if.ready, 1'b0);
    @(posedge clk); #1;

    // ---------------- stall isolation ----------------
    c0done = -1; c1done = -1; m0cyc = 0;
    m0_if.valid = 1'b1; m0_if.addr = 32'h0000_0100; m0_if.wstrb = 4'h0;
    for (int c = 0; c < 40 && c1done < 0; c++) begin
      if (c == 2) begin
        m1_if.valid = 1'b1; m1_if.addr = 32'h0000_0500;
        m1_if.wdata = 32'hAABB_CCDD; m1_if.wstrb = 4'b0011;
      end
      if (c0done >= 0) m0_if.valid = 1'b0;
      mem_if.ready = (c0done >= 0) ? 1'b1 : (m0cyc == 10);
      @(negedge clk);
      if (grant == 2'b01) begin
        m0cyc++;
        chk("stall_owner_addr", mem_if.addr, 32'h0000_0100);
        chkb("stall_m1_ready", m1_if.ready, 1'b0);
        if (m0_if.ready) c0done = c;
      end
      if (grant == 2'b10 && m1_if.ready) begin
        c1done = c;
        chk("stall_m1_wdata", mem_if.wdata, 32'hAABB_CCDD);
        chk("stall_m1_wstrb", 32'(mem_if.wstrb), 32'd3);
      end
      @(posedge clk); #1;
    end
    chk("stall_m0_cycles", 32'(m0cyc), 32'd11);
    chk("stall_m1_gap", 32'(c1done - c0done), 32'd2);
    idle_inputs();
    @(posedge clk); #1;

    // ---------------- reset mid-transfer ----------------
    m0_if.valid = 1'b1; m0_if.addr = 32'h0000_0300;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstmid_pre_grant", 32'(grant), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; m1_if.valid = 1'b1; m1_if.addr = 32'h0000_0600;
    @(posedge clk); #1;
    rst = 1'b0; mem_if.ready = 1'b1;
    @(negedge clk);
    chk("rstmid_grant", 32'(grant), 32'd0);
    chkb("rstmid_mem_valid", mem_if.valid, 1'b0);
    chkb("rstmid_m0_ready", m0_if.ready, 1'b0);
    chkb("rstmid_m1_ready", m1_if.ready, 1'b0);
    @(posedge clk); #1 mem_if.ready = 1'b0;
    @(negedge clk);
    chk("rstmid_tie_m0_first", 32'(grant), 32'd1);
    do_reset();

`ifdef BUS_TIMEOUT_EN
    // ---------------- watchdog ----------------
    xfer(0, 32'hFFFF_0700, -1, 32'h5555_5555, bc, rd, mvd);
    chk("to_busy_cycles", 32'(bc), 32'd8);
    chk("to_rdata", rd, ERR_D);
    chkb("to_mem_valid_forced_low", mvd, 1'b0);
    chkb("to_bus_err", bus_err, 1'b1);
    chk("to_err_addr", err_addr, 32'hFFFF_0700);
    xfer(1, 32'h0000_1234, -1, 32'h5555_5555, bc, rd, mvd);
    chk("to2_busy_cycles", 32'(bc), 32'd8);
    chk("to2_err_addr_kept", err_addr, 32'hFFFF_0700);
    err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    chkb("to_clr_bus_err", bus_err, 1'b0);
    chk("to_clr_err_addr", err_addr, 32'h0);
    xfer(0, 32'h0000_0040, 7, 32'hCAFE_F00D, bc, rd, mvd);
    chk("toedge_busy_cycles", 32'(bc), 32'd8);
    chk("toedge_rdata", rd, 32'hCAFE_F00D);
    chkb("toedge_mem_valid", mvd, 1'b1);
    chkb("toedge_bus_err", bus_err, 1'b0);
`endif

    // ---------------- randomized run against reference model ----------------
    do_reset();
    owner = -1; last = 1; bcnt = 0; err_m = 1'b0; erra_m = 32'h0; pend = 2'b00;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic ov, to, er0, er1, emv;
      if (!pend[0] && ($urandom_range(2) == 0)) begin
        pend[0] = 1'b1; m0_if.addr = $urandom; m0_if.wdata = $urandom; m0_if.wstrb = 4'($urandom);
      end
      if (!pend[1] && ($urandom_range(2) == 0)) begin
        pend[1] = 1'b1; m1_if.addr = $urandom; m1_if.wdata = $urandom; m1_if.wstrb = 4'($urandom);
      end
      m0_if.valid  = pend[0];
      m1_if.valid  = pend[1];
      mem_if.ready = (owner >= 0) && ($urandom_range(2) == 0);
      mem_if.rdata = $urandom;
      err_clr      = ($urandom_range(19) == 0);
      @(negedge clk);
      ov = (owner == 0) ? m0_if.valid : ((owner == 1) ? m1_if.valid : 1'b0);
      to = 1'b0;
`ifdef BUS_TIMEOUT_EN
      to = ov && !mem_if.ready && (bcnt == int'(TB_TO) - 1);
`endif
      emv = ov && !to;
      er0 = (owner == 0) && ov && (mem_if.ready || to);
      er1 = (owner == 1) && ov && (mem_if.ready || to);
      exp_a = (owner == 1) ? m1_if.addr : m0_if.addr;
      chk("rnd_grant", 32'(grant), (owner < 0) ? 32'd0 : ((owner == 0) ? 32'd1 : 32'd2));
      chkb("rnd_mem_valid", mem_if.valid, emv);
      chkb("rnd_m0_ready", m0_if.ready, er0);
      chkb("rnd_m1_ready", m1_if.ready, er1);
      chkb("rnd_bus_err", bus_err, err_m);
      chk("rnd_err_addr", err_addr, erra_m);
      if (emv) begin
        chk("rnd_mem_addr", mem_if.addr, exp_a);
        chk("rnd_mem_wdata", mem_if.wdata, (owner == 1) ? m1_if.wdata : m0_if.wdata);
        chk("rnd_mem_wstrb", 32'(mem_if.wstrb), 32'((owner == 1) ? m1_if.wstrb : m0_if.wstrb));
      end
      if (er0 || er1) chk("rnd_rdata", er1 ? m1_if.rdata : m0_if.rdata, to ? ERR_D : mem_if.rdata);
      if (er0) pend[0] = 1'b0;
      if (er1) pend[1] = 1'b0;
      if (err_clr) begin
        err_m = 1'b0; erra_m = 32'h0;
      end else if (to && !err_m) begin
        err_m = 1'b1; erra_m = exp_a;
      end
      if (owner < 0) begin
        if (m0_if.valid && m1_if.valid) owner = (last == 1) ? 0 : 1;
        else if (m0_if.valid)           owner = 0;
        else if (m1_if.valid)           owner = 1;
        if (owner >= 0) begin last = owner; bcnt = 0; end
      end else if (!ov || mem_if.ready || to) begin
        owner = -1;
      end else begin
        bcnt++;
      end
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sys_bus_arbiter.md
# sys_bus_arbiter

Two-master arbiter in front of `sys_bus` address decode. Shares the single native memory port (`valid`/`ready`, 32-bit address and data, 4-bit write strobe) between the CPU (master 0) and a second bus master such as the DMA/bridge (master 1). Uses round-robin arbitration and holds each grant for a complete transfer. Optionally includes a watchdog that terminates transfers a slave never acknowledges.

## Interface
- `TIMEOUT`, 256, max cycles a granted transfer may wait for `mem_ready` (used only with `BUS_TIMEOUT_EN`); legal range 2..65535.
- `ERR_DATA`, 32'hDEADBEEF, read data returned on a timed-out transfer.

Ports (clock and reset first):
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `m0_valid`, `m1_valid`  in  1  request from master 0 / 1; held until matching ready.
- `m0_addr`, `m1_addr`  in  32  byte address.
- `m0_wdata`, `m1_wdata`  in  32  write data.
- `m0_wstrb`, `m1_wstrb`  in  4  byte strobes; 0 = read.
- `m0_ready`, `m1_ready`  out  1  one-cycle completion pulse to the granted master.
- `m0_rdata`, `m1_rdata`  out  32  read data, valid while the matching ready is high.
- `mem_valid`  out  1  request to `sys_bus`.
- `mem_addr`, `mem_wdata`  out  32  forwarded from the granted master.
- `mem_wstrb`  out  4  forwarded strobes.
- `mem_ready`  in  1  completion from `sys_bus`.
- `mem_rdata`  in  32  read data from `sys_bus`.
- `grant`  out  2  one-hot current owner; 0 when idle.
- `bus_err`  out  1  sticky timeout flag.
- `err_addr`  out  32  address of the first timed-out transfer.
- `err_clr`  in  1  clears `bus_err` and `err_addr`.

## Operation
- FSM states:
  - **IDLE**, `grant`=0, `mem_valid`=0.
  - **BUSY**, one `grant` bit set.
- **IDLE→BUSY** when any `mX_valid`=1.
  - Single requester wins.
  - If both request, the master other than `last_grant` wins (round-robin); `last_grant` is updated on entry to BUSY.
- **BUSY:**
  - `mem_valid` = granted master's valid.
  - `mem_addr`, `mem_wdata`, `mem_wstrb` = granted master's signals, muxed combinationally by the `grant` register.
  - `mX_ready` = `mem_ready & grant[X]`; `mX_rdata` = `mem_rdata` (both masters see it; only the ready qualifies it).
  - The non-granted master is stalled, with ready held at 0.
- **BUSY→IDLE** on `mem_ready`=1, or on timeout.
- A granted master dropping valid without ready (illegal) also returns to IDLE; no ready is generated.
- Every transfer passes through IDLE, so two back-to-back requests from the same master need a turnaround cycle.
- **Watchdog:**
  - 16-bit counter, cleared on entry to BUSY, incremented each BUSY cycle without `mem_ready`.
  - When the counter reaches `TIMEOUT`−1 with no `mem_ready`:
    - the arbiter drives `mX_ready`=1 and `mX_rdata`=`ERR_DATA` for that cycle;
    - `mem_valid` is forced to 0 that cycle;
    - the FSM returns to IDLE.
  - If `bus_err` was 0, it sets `bus_err`=1 and captures `mem_addr` into `err_addr`; later timeouts do not overwrite.
  - `mem_ready` arriving in the same cycle as the timeout wins: normal completion, no error.
  - `err_clr` has priority over a same-cycle new error.

## Timing
- Reset values:
  - state IDLE, `grant`=0, `last_grant`=1 (master 0 wins the first tie);
  - `mem_valid`=0, `m0_ready`=`m1_ready`=0;
  - counter 0, `bus_err`=0, `err_addr`=0.
- Arbitration latency: 1 cycle. Valid sampled in IDLE at edge N; `mem_valid` is asserted in cycle N+1.
- Completion: `mX_ready` is combinational from `mem_ready`, in the same cycle. `mem_valid` is 0 in the following cycle.
- Minimum transfer: 2 cycles (IDLE + BUSY with an immediate ready). Sustained alternating two-master throughput is one transfer per 2 cycles.
- `rst` asserted mid-transfer: IDLE at the next edge. The transfer is abandoned and no ready is sent to the master.
- Address decode and slave selection stay in `sys_bus`; this block is address-agnostic.

## Configuration
- `BUS_TIMEOUT_EN` defined:
  - watchdog counter, `ERR_DATA` response, `bus_err`, `err_addr` and `err_clr` are active as described.
- Undefined:
  - no counter is built; BUSY waits indefinitely for `mem_ready`;
  - `bus_err`=0 and `err_addr`=0 constantly; `err_clr` is ignored.

## Test plan
- **Single read:** m0 read at 0x00000100, slave ready 3 cycles after `mem_valid` with 0x12345678 → `grant`=01, `m0_ready` pulses once with `m0_rdata`=0x12345678, `m1_ready` stays 0.
- **Tie fairness:** both valid from reset, each slave response takes 1 cycle → grant order m0, m1, m0, m1. Each master gets exactly one ready per grant, and `mem_wstrb`/`mem_addr` match the owner.
- **Stall isolation:** m1 writes 0xAABBCCDD with wstrb 4'b0011 while m0 is granted with ready delayed 10 cycles → m1 is not forwarded until m0 completes. m1 is then granted in the IDLE cycle after, with `mem_wdata`=0xAABBCCDD.
- **Timeout** (macro on, `TIMEOUT`=8): slave never asserts ready on m0 read at 0xFFFF0700 → `m0_ready` on the 8th BUSY cycle with rdata 0xDEADBEEF, `bus_err`=1, `err_addr`=0xFFFF0700. A second timeout leaves `err_addr` unchanged; `err_clr` zeroes both.
- **Timeout edge:** `mem_ready` in exactly the 8th BUSY cycle → normal rdata returned, `bus_err` stays 0.
- **Reset mid-transfer:** `rst` pulsed in BUSY → next cycle `grant`=0, `mem_valid`=0, no ready pulse. After release, a pending m1 request is granted first if the pre-reset tie state would have chosen m1? No: `last_grant` resets to 1, so on a tie m0 is granted first.
